// File: rtl/tiled_loop_iterator_if.sv
// Handshake and index bus between the loop-nest sequencer and its consumer.
// slave modport: the sequencer (takes start/ready, drives tuple + status).
// master modport: the consumer/controller (drives start/ready, reads tuple).
// Widths follow w(X) = max(1, clog2(X)) for each index range.
interface tiled_loop_iterator_if #(
  parameter int unsigned N_p = 4,
  parameter int unsigned M_p = 4,
  parameter int unsigned K_p = 2,
  parameter int unsigned R_p = 16,
  parameter int unsigned C_p = 16,
  parameter int unsigned S_p = 1
) ();

  function automatic int unsigned wid(input int unsigned x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  localparam int unsigned KW  = wid(K_p);
  localparam int unsigned TIW = wid(N_p);
  localparam int unsigned TOW = wid(M_p);
  localparam int unsigned CW  = wid(C_p);
  localparam int unsigned RW  = wid(R_p);
  localparam int unsigned ICW = wid((C_p - 1) * S_p + K_p);
  localparam int unsigned IRW = wid((R_p - 1) * S_p + K_p);

  logic           start_i;
  logic           ready_i;
  logic           valid_o;
  logic [KW-1:0]  j_o;
  logic [KW-1:0]  i_o;
  logic [TIW-1:0] ti_o;
  logic [TOW-1:0] to_o;
  logic [CW-1:0]  col_o;
  logic [RW-1:0]  row_o;
  logic [ICW-1:0] in_col_o;
  logic [IRW-1:0] in_row_o;
  logic [5:0]     wrap_o;
  logic           last_o;
  logic           busy_o;
  logic           done_o;

  modport slave (
    input  start_i, ready_i,
    output valid_o, j_o, i_o, ti_o, to_o, col_o, row_o,
           in_col_o, in_row_o, wrap_o, last_o, busy_o, done_o
  );

  modport master (
    output start_i, ready_i,
    input  valid_o, j_o, i_o, ti_o, to_o, col_o, row_o,
           in_col_o, in_row_o, wrap_o, last_o, busy_o, done_o
  );

endinterface

// File: rtl/tiled_loop_iterator.sv
// Six-deep convolution loop-nest sequencer (row, col, to, ti, i, j; j innermost).
// Latency: first tuple valid 1 cycle after start; done pulse 1 cycle after last handshake.
// Backpressure: with ready low every output holds stable; the odometer only moves on valid&ready.
// Ports: clk_i, reset_i (async active-low) plus bus (slave modport): start/ready in;
// valid, index tuple, derived input-map coordinates, wrap flags, last/busy/done out.
module tiled_loop_iterator #(
  parameter int unsigned N_p  = 4,
  parameter int unsigned M_p  = 4,
  parameter int unsigned K_p  = 2,
  parameter int unsigned R_p  = 16,
  parameter int unsigned C_p  = 16,
  parameter int unsigned Tn_p = 2,
  parameter int unsigned Tm_p = 2,
  parameter int unsigned S_p  = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  tiled_loop_iterator_if.slave  bus
);

  function automatic int unsigned wid(input int unsigned x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  localparam int unsigned KW  = wid(K_p);
  localparam int unsigned TIW = wid(N_p);
  localparam int unsigned TOW = wid(M_p);
  localparam int unsigned CW  = wid(C_p);
  localparam int unsigned RW  = wid(R_p);
  localparam int unsigned ICW = wid((C_p - 1) * S_p + K_p);
  localparam int unsigned IRW = wid((R_p - 1) * S_p + K_p);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [KW-1:0]  j_q, j_d;
  logic [KW-1:0]  i_q, i_d;
  logic [TIW-1:0] ti_q, ti_d;
  logic [TOW-1:0] to_q, to_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;

  logic [5:0] lvl_last;  // level k sits on its final value
  logic [5:0] wrap;      // level k and every inner level are final
  logic       run;
  logic       fire;

  assign run  = (state_q == ST_RUN);
  assign fire = run & bus.ready_i;

  // Tile levels are final once the next stride would reach the bound, so a
  // partial last tile (N_p not a multiple of Tn_p) still terminates the level.
  always_comb begin
    lvl_last[0] = (32'(j_q)   + 32'd1) >= K_p;
    lvl_last[1] = (32'(i_q)   + 32'd1) >= K_p;
    lvl_last[2] = (32'(ti_q)  + Tn_p)  >= N_p;
    lvl_last[3] = (32'(to_q)  + Tm_p)  >= M_p;
    lvl_last[4] = (32'(col_q) + 32'd1) >= C_p;
    lvl_last[5] = (32'(row_q) + 32'd1) >= R_p;
    wrap[0] = lvl_last[0];
    for (int k = 1; k < 6; k++) begin
      wrap[k] = wrap[k-1] & lvl_last[k];
    end
  end

  // Odometer: level k steps only when every inner level wraps (wrap[k-1]).
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    i_d     = i_q;
    ti_d    = ti_q;
    to_d    = to_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (wrap[5]) begin
            state_d = ST_DONE;
            j_d     = '0;
            i_d     = '0;
            ti_d    = '0;
            to_d    = '0;
            col_d   = '0;
            row_d   = '0;
          end else begin
            j_d = lvl_last[0] ? '0 : j_q + KW'(1);
            if (wrap[0]) i_d   = lvl_last[1] ? '0 : i_q + KW'(1);
            if (wrap[1]) ti_d  = lvl_last[2] ? '0 : ti_q + TIW'(Tn_p);
            if (wrap[2]) to_d  = lvl_last[3] ? '0 : to_q + TOW'(Tm_p);
            if (wrap[3]) col_d = lvl_last[4] ? '0 : col_q + CW'(1);
            if (wrap[4]) row_d = lvl_last[5] ? '0 : row_q + RW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      i_q     <= '0;
      ti_q    <= '0;
      to_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      i_q     <= i_d;
      ti_q    <= ti_d;
      to_q    <= to_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign bus.valid_o  = run;
  assign bus.busy_o   = run;
  assign bus.done_o   = (state_q == ST_DONE);
  assign bus.j_o      = j_q;
  assign bus.i_o      = i_q;
  assign bus.ti_o     = ti_q;
  assign bus.to_o     = to_q;
  assign bus.col_o    = col_q;
  assign bus.row_o    = row_q;
  // Flags are masked outside RUN so degenerate size-1 levels do not show
  // wrap/last while idle.
  assign bus.wrap_o   = run ? wrap : 6'd0;
  assign bus.last_o   = run & wrap[5];
  assign bus.in_col_o = ICW'(32'(col_q) * S_p + 32'(j_q));
  assign bus.in_row_o = IRW'(32'(row_q) * S_p + 32'(i_q));

endmodule

// File: doc/tiled_loop_iterator.md
Name: tiled_loop_iterator

Overview:
- Generalised loop-nest sequencer for the CNN datapath. Walks the six-deep convolution nest (row, col, to, ti, i, j; j innermost) with tile strides Tn/Tm and convolution stride S.
- Emits one index tuple per valid/ready handshake, plus derived input-feature-map coordinates.
- Adds start/busy/done control, backpressure stalling, and per-level wrap flags, so the datapath can fire tile-boundary actions such as accumulator flush and buffer swap.

Parameters:
- N_p, 4, input channels
- M_p, 4, output channels
- K_p, 2, kernel size (K×K)
- R_p, 16, output rows
- C_p, 16, output cols
- Tn_p, 2, input-channel tile stride (1..N_p)
- Tm_p, 2, output-channel tile stride (1..M_p)
- S_p, 1, convolution stride (≥1)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- start_i  in  1  begin a full nest walk; sampled in IDLE only
- ready_i  in  1  consumer accepts current tuple
- valid_o  out  1  tuple on index outputs is valid
- j_o  out  w(K_p)  kernel column
- i_o  out  w(K_p)  kernel row
- ti_o  out  w(N_p)  input-channel tile base
- to_o  out  w(M_p)  output-channel tile base
- col_o  out  w(C_p)  output column
- row_o  out  w(R_p)  output row
- in_col_o  out  w((C_p-1)*S_p+K_p)  col*S_p + j
- in_row_o  out  w((R_p-1)*S_p+K_p)  row*S_p + i
- wrap_o  out  6  per-level "this tuple is the level's last", bit0=j … bit5=row
- last_o  out  1  current tuple is the final tuple of the walk (= &wrap_o)
- busy_o  out  1  state is RUN
- done_o  out  1  one-cycle pulse after the final handshake

Behaviour:
- Width rule: w(X) = max(1, $clog2(X)).
- Reset (reset_i low, asynchronous):
  - state = IDLE.
  - All indices = 0.
  - valid_o, busy_o, done_o, last_o = 0; wrap_o = 0.
  - Reset mid-walk aborts immediately. No done_o is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - valid_o = 0 and indices held at 0.
  - start_i = 1 → RUN on the next edge. The first tuple (all zeros) is presented with valid_o = 1 in the following cycle.
- RUN:
  - valid_o = 1 continuously.
  - Handshake fires when valid_o & ready_i.
  - No handshake → all outputs held stable (stall), for any number of cycles.
  - On handshake, the odometer advances:
    - j += 1. j wraps to 0 at K_p-1 and carries.
    - i is the same as j, with the carry enabled by j's wrap.
    - ti += Tn_p. ti wraps to 0 when ti + Tn_p ≥ N_p; partial final tiles are allowed.
    - to += Tm_p, with the same wrap rule against M_p.
    - col and row advance by 1, wrapping at C_p-1 and R_p-1.
  - Handshake with last_o = 1 → DONE. Indices return to 0.
- DONE:
  - valid_o = 0 and done_o = 1 for exactly one cycle.
  - Then → IDLE. start_i is ignored in DONE.
- start_i is ignored while in RUN.
- wrap_o[k] is combinational from the current indices:
  - Set when level k and every inner level are at their final value.
  - Example: wrap_o[2] means j, i and ti are all last.
- in_col_o / in_row_o are combinational from the current indices. No overflow by construction of the widths.
- Latency:
  - start_i to first valid_o: 1 cycle.
  - Last handshake to done_o: 1 cycle.
- Total tuples per walk = K_p² · ceil(N_p/Tn_p) · ceil(M_p/Tm_p) · C_p · R_p.
- Degenerate sizes:
  - K_p = 1 → j and i are constant 0, and their wrap bits are always 1.
  - Any level of size 1 behaves the same way.

Test Plan:
- Defaults with R_p=C_p=2, ready_i held 1, start pulse → exactly 64 handshakes, valid_o unbroken.
  - Order: j fastest, then i, then ti ∈{0,2}, then to ∈{0,2}, then col, then row.
  - last_o only on tuple 63.
  - done_o one cycle after tuple 63, then IDLE.
- ready_i toggled pseudo-randomly → identical 64-tuple sequence. Outputs stable during every stall cycle.
- N_p=5, Tn_p=2 → ti sequence 0,2,4,0. wrap_o[2] asserted on tuples with ti=4, i=1, j=1.
- S_p=2, K_p=3, R_p=C_p=3 → in_col_o spans 0..6 and in_row_o spans 0..6. Tuple (row=2, col=1, i=2, j=0) gives in_row_o=6, in_col_o=2.
- Assert reset_i low mid-walk asynchronously → all outputs 0 immediately, no done_o. Next start_i restarts from all-zero.
- start_i pulsed during RUN and during DONE → ignored; exactly one walk and one done_o.
